// File: rtl/pelota.sv
// pelota: ball controller for the pong datapath.
// Moves a BALL_S x BALL_S ball around a WIDTH x HEIGHT field one pixel per
// prescaler step, bouncing off the top, bottom and right walls and off the
// paddle face at column BAR_X. A miss is flagged when the ball leaves the
// left edge, after which the ball is re-centred and waits for a serve.
module pelota #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int BALL_S  = 8,
  parameter int BAR_X   = 16,
  parameter int BAR_H   = 64,
  parameter int VEL_DIV = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] barra_y,
  input  logic       start,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       miss,
  output logic [7:0] hits,
  output logic       jugando,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_e;

  localparam logic [9:0] X_C   = 10'((WIDTH - BALL_S) / 2);
  localparam logic [9:0] Y_C   = 10'((HEIGHT - BALL_S) / 2);
  localparam logic [9:0] X_MAX = 10'(WIDTH - BALL_S);
  localparam logic [9:0] Y_MAX = 10'(HEIGHT - BALL_S);
  localparam logic [9:0] X_BAR = 10'(BAR_X);

  // A divide of 1 still needs a one-bit counter that stays at zero.
  localparam int PW = (VEL_DIV > 1) ? $clog2(VEL_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(VEL_DIV - 1);

  state_e state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic          step;

  // Directions: 1 means +1 (right / down), 0 means -1 (left / up).
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic [7:0] hits_q, hits_d;
  logic       miss_q, miss_d;

  logic [10:0] y_ext, bar_ext;
  logic        overlap;
  logic        hit_right, hit_bar, hit_left;

  // Free-running move prescaler; step fires on its terminal count.
  always_comb begin
    step    = (presc_q == PRESC_MAX);
    presc_d = step ? '0 : presc_q + PW'(1);
  end

  // Collision decode; 11-bit compare so a large barra_y cannot wrap.
  always_comb begin
    y_ext     = {1'b0, y_q};
    bar_ext   = {1'b0, barra_y};
    overlap   = ((y_ext + 11'(BALL_S)) > bar_ext) &&
                (y_ext < (bar_ext + 11'(BAR_H)));
    hit_right = (x_q == X_MAX) && dx_q;
    hit_bar   = !hit_right && (x_q == X_BAR) && !dx_q && overlap;
    hit_left  = !hit_right && !hit_bar && (x_q == 10'd0) && !dx_q;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= SERVE;
    else        state_q <= state_d;
  end

  // FSM next state: serve on start, miss on a left-edge exit, miss lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE:   if (start) state_d = PLAY;
      PLAY:    if (step && hit_left) state_d = MISS;
      MISS:    state_d = SERVE;
      default: state_d = SERVE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    jugando   = (state_q == PLAY);
    state_dbg = state_q;
  end

  // Ball datapath next state: motion on steps in PLAY, re-centre on entry to SERVE.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    dx_d   = dx_q;
    dy_d   = dy_q;
    hits_d = hits_q;
    miss_d = 1'b0;
    case (state_q)
      SERVE: begin
        x_d  = X_C;
        y_d  = Y_C;
        dx_d = 1'b1;
        dy_d = 1'b1;
      end
      PLAY: begin
        if (step) begin
          if (hit_left) begin
            // Ball frozen where it left; the miss cycle follows.
            miss_d = 1'b1;
            hits_d = 8'd0;
          end else begin
            // Vertical: a wall flip takes effect in the same step.
            if ((y_q == 10'd0) && !dy_q) begin
              dy_d = 1'b1;
              y_d  = y_q + 10'd1;
            end else if ((y_q == Y_MAX) && dy_q) begin
              dy_d = 1'b0;
              y_d  = y_q - 10'd1;
            end else begin
              y_d  = dy_q ? (y_q + 10'd1) : (y_q - 10'd1);
            end
            // Horizontal: right wall, then paddle face, then free motion.
            if (hit_right) begin
              dx_d = 1'b0;
              x_d  = x_q - 10'd1;
            end else if (hit_bar) begin
              dx_d   = 1'b1;
              x_d    = x_q + 10'd1;
              hits_d = (hits_q == 8'hFF) ? hits_q : (hits_q + 8'd1);
            end else begin
              x_d  = dx_q ? (x_q + 10'd1) : (x_q - 10'd1);
            end
          end
        end
      end
      MISS: begin
        x_d  = X_C;
        y_d  = Y_C;
        dx_d = 1'b1;
        dy_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Ball datapath and prescaler registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      x_q     <= X_C;
      y_q     <= Y_C;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      hits_q  <= 8'd0;
      miss_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      hits_q  <= hits_d;
      miss_q  <= miss_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign hits = hits_q;
  assign miss = miss_q;

endmodule

// File: doc/pelota.md
Name: pelota

Overview:
- Ball controller for the pong datapath; consumes the paddle position word produced by the paddle block (10-bit top-edge y).
- Moves a BALL_S×BALL_S ball across a WIDTH×HEIGHT field.
- Bounces off the top, bottom and right walls and off the paddle face.
- Signals a miss when the ball reaches the left edge. Outputs ball x/y to the VGA renderer.

Parameters:
WIDTH, 640, field width in pixels
HEIGHT, 480, field height in pixels
BALL_S, 8, ball side in pixels
BAR_X, 16, paddle column: x of the paddle's right face, where the ball's left edge collides
BAR_H, 64, paddle height in pixels
VEL_DIV, 200000, clk cycles per one-pixel move step (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
barra_y  input  10  paddle top edge y, from paddle block
start  input  1  serve request, level-sensed
x  output  10  ball left edge x
y  output  10  ball top edge y
miss  output  1  one-cycle pulse when ball exits left edge
hits  output  8  paddle returns since last miss, saturating
jugando  output  1  high while state is PLAY

Behaviour:
- Reset (reset low, async):
  - state=SERVE; x=(WIDTH-BALL_S)/2 (316); y=(HEIGHT-BALL_S)/2 (236).
  - dx=+1 (right), dy=+1 (down); miss=0; hits=0; prescaler=0; jugando=0.
- Prescaler:
  - Counts 0..VEL_DIV-1 and wraps. Free-running in all states; cleared only by reset.
  - step=1 in the cycle where prescaler==VEL_DIV-1.
- State SERVE:
  - x and y are held at the centre values, dx=+1, dy=+1.
  - start sampled high on any clk edge -> PLAY on that edge. Motion begins on the next step.
- State PLAY, on each step:
  - Vertical: y==0 with dy=-1, or y==HEIGHT-BALL_S with dy=+1 -> flip dy and apply the new direction in the same step (y moves 1 away from the wall). Otherwise y+=dy.
  - Horizontal, priority order:
    1. x==WIDTH-BALL_S with dx=+1 -> flip dx, x-=1.
    2. x==BAR_X with dx=-1 and overlap -> flip dx, x+=1, hits+=1 (saturates at 255).
    3. x==0 with dx=-1 -> go to MISS; x and y unchanged.
    4. Otherwise x+=dx.
  - Overlap is defined as (y+BALL_S > barra_y) && (y < barra_y+BAR_H). Evaluate it with 11-bit arithmetic, so out-of-range barra_y values (e.g. 1000) never wrap.
  - barra_y and y are both sampled in the step cycle.
  - No overlap at x==BAR_X: the ball continues left past the paddle. Collision is tested only at x==BAR_X.
  - Corner case: vertical and horizontal flips in the same step are both applied.
  - Outside step cycles, x, y, dx and dy hold.
- State MISS: lasts exactly one cycle.
  - miss=1 (registered output, high during this cycle); hits cleared to 0.
  - Next cycle: SERVE with the centre position restored.
- Outputs:
  - x and y are registered; they change only on a step, on entry to SERVE, or on reset.
  - jugando=1 iff state==PLAY.
- start held high:
  - After a miss, the block re-serves through SERVE after one cycle in SERVE.
  - start is ignored in PLAY and MISS.
- Reset asserted mid-PLAY: immediate return to reset values, with no miss pulse.

Test Plan:
1. VEL_DIV=2; release reset, start=0 for 20 cycles -> x=316, y=236, jugando=0, no motion. Pulse start -> jugando=1; after 10 steps x=326, y=246.
2. Bottom/top bounce: run with dy=+1 until y=472 -> next step y=471, dy=-1. Continue to y=0 -> next step y=1.
3. Right wall: reach x=632 with dx=+1 -> next step x=631, dx=-1, hits unchanged.
4. Paddle hit: barra_y=200, ball reaches x=16 with y=230 (overlap) -> next step x=17, dx=+1, hits=1. Repeat with y=263 (edge overlap) -> hit. Repeat with y=264 -> no hit.
5. Miss: barra_y=0, ball arrives at x=16 with y=300 -> passes to x=15, then down to x=0. Next step -> miss high exactly 1 cycle, hits=0, next cycle x=316, y=236, jugando=0.
6. Async reset mid-flight: assert reset low between clk edges while x=100 -> x=316, y=236, hits=0, miss=0 immediately, without waiting for a clk edge.
